// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep memory responder: FSM state encoding and the
// request-attribute tuple that both core copies must agree on.
package lockstep_pkg;

  // Attribute tuples are sized for buses up to 32-bit address/data; narrower
  // instances zero-extend into them.
  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = BUS_DW / 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_L   = 3'd1,
    ST_WAIT_R   = 3'd2,
    ST_GRANT    = 3'd3,
    ST_RESP     = 3'd4,
    ST_DIVERGED = 3'd5
  } resp_state_e;

  typedef struct packed {
    logic               we;
    logic [BUS_BEW-1:0] be;
    logic [BUS_AW-1:0]  addr;
    logic [BUS_DW-1:0]  wdata;
  } bus_req_t;

  function automatic logic req_equal(input bus_req_t a, input bus_req_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/lockstep_skew_ctr.sv
// Saturating wait counter; o_ovf flags an increment request that would push
// the count past MAX.
module lockstep_skew_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != W'(MAX))) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_ovf   = i_inc && (r_count == W'(MAX));

endmodule

// File: rtl/lockstep_mem_responder.sv
// Shared memory responder for the Left/Right lockstep copies: one identical
// response to both lanes, skew absorption up to MAX_SKEW, sticky divergence.
module lockstep_mem_responder
  import lockstep_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_SKEW = 4,
  parameter int RESP_LAT = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          left_req_i,
  input  logic                          left_we_i,
  input  logic [DW/8-1:0]               left_be_i,
  input  logic [AW-1:0]                 left_addr_i,
  input  logic [DW-1:0]                 left_wdata_i,
  output logic                          left_gnt_o,
  output logic                          left_rvalid_o,
  output logic [DW-1:0]                 left_rdata_o,
  output logic                          left_err_o,
  input  logic                          right_req_i,
  input  logic                          right_we_i,
  input  logic [DW/8-1:0]               right_be_i,
  input  logic [AW-1:0]                 right_addr_i,
  input  logic [DW-1:0]                 right_wdata_i,
  output logic                          right_gnt_o,
  output logic                          right_rvalid_o,
  output logic [DW-1:0]                 right_rdata_o,
  output logic                          right_err_o,
  input  logic [DW-1:0]                 stim_rdata_i,
  input  logic                          stim_err_i,
  output logic [$clog2(MAX_SKEW+1)-1:0] skew_o,
  output logic                          diverge_o,
  output logic                          protocol_err_o
);

  localparam int SKEW_W = $clog2(MAX_SKEW + 1);
  localparam int LAT_W  = $clog2(RESP_LAT + 1);

  resp_state_e       r_state;
  logic              r_gnt;
  logic              r_rvalid;
  logic              r_diverge;
  logic              r_proto_err;
  logic              r_rsp_we;
  logic              r_rsp_err;
  logic [DW-1:0]     r_rsp_data;
  logic [LAT_W-1:0]  r_lat;

  bus_req_t          w_left_attr;
  bus_req_t          w_right_attr;
  logic              w_attr_match;
  logic              w_both_req;
  logic              w_waiter_dropped;
  logic              w_skew_clr;
  logic              w_skew_inc;
  logic              w_skew_ovf;
  logic [SKEW_W-1:0] w_skew;

  assign w_left_attr  = '{we: left_we_i, be: BUS_BEW'(left_be_i),
                          addr: BUS_AW'(left_addr_i), wdata: BUS_DW'(left_wdata_i)};
  assign w_right_attr = '{we: right_we_i, be: BUS_BEW'(right_be_i),
                          addr: BUS_AW'(right_addr_i), wdata: BUS_DW'(right_wdata_i)};
  assign w_attr_match = req_equal(w_left_attr, w_right_attr);
  assign w_both_req   = left_req_i && right_req_i;

  // The lane already waiting must keep req high until its partner shows up.
  assign w_waiter_dropped = ((r_state == ST_WAIT_L) && !right_req_i) ||
                            ((r_state == ST_WAIT_R) && !left_req_i);

  always_comb begin
    w_skew_clr = 1'b0;
    w_skew_inc = 1'b0;
    case (r_state)
      ST_IDLE:   w_skew_inc = left_req_i ^ right_req_i;
      ST_WAIT_L,
      ST_WAIT_R: begin
        if (w_waiter_dropped) begin
          w_skew_clr = 1'b1;
        end else if (!w_both_req) begin
          w_skew_inc = 1'b1;
        end
      end
      ST_GRANT:  w_skew_clr = 1'b1;
      default:   ;
    endcase
  end

  lockstep_skew_ctr #(
    .MAX (MAX_SKEW),
    .W   (SKEW_W)
  ) u_skew_ctr (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_clr   (w_skew_clr),
    .i_inc   (w_skew_inc),
    .o_count (w_skew),
    .o_ovf   (w_skew_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 1'b0;
      r_rvalid    <= 1'b0;
      r_diverge   <= 1'b0;
      r_proto_err <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_lat       <= '0;
    end else begin
      r_gnt <= 1'b0;
      case (r_state)
        ST_IDLE, ST_WAIT_L, ST_WAIT_R: begin
          if (w_waiter_dropped) begin
            r_proto_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_both_req) begin
            if (w_attr_match) begin
              r_state  <= ST_GRANT;
              r_gnt    <= 1'b1;
              r_rsp_we <= left_we_i;
            end else begin
              r_state   <= ST_DIVERGED;
              r_diverge <= 1'b1;
            end
          end else if (r_state == ST_IDLE) begin
            if (right_req_i) begin
              r_state <= ST_WAIT_L;
            end else if (left_req_i) begin
              r_state <= ST_WAIT_R;
            end
          end else if (w_skew_ovf) begin
            r_state   <= ST_DIVERGED;
            r_diverge <= 1'b1;
          end
        end
        ST_GRANT: begin
          r_rsp_data <= stim_rdata_i;
          r_rsp_err  <= stim_err_i;
          r_lat      <= LAT_W'(1);
          r_state    <= ST_RESP;
          if (RESP_LAT == 1) begin
            r_rvalid <= 1'b1;
          end
        end
        // Requests arriving here are left pending and picked up from IDLE.
        ST_RESP: begin
          if (r_rvalid) begin
            r_rvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
            if ((r_lat + LAT_W'(1)) == LAT_W'(RESP_LAT)) begin
              r_rvalid <= 1'b1;
            end
          end
        end
        ST_DIVERGED: r_state <= ST_DIVERGED;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign left_gnt_o     = r_gnt;
  assign right_gnt_o    = r_gnt;
  assign left_rvalid_o  = r_rvalid;
  assign right_rvalid_o = r_rvalid;
  assign left_rdata_o   = (r_rvalid && !r_rsp_we) ? r_rsp_data : '0;
  assign right_rdata_o  = (r_rvalid && !r_rsp_we) ? r_rsp_data : '0;
  assign left_err_o     = r_rvalid && r_rsp_err;
  assign right_err_o    = r_rvalid && r_rsp_err;
  assign skew_o         = w_skew;
  assign diverge_o      = r_diverge;
  assign protocol_err_o = r_proto_err;

endmodule

// File: tb/tb_lockstep_mem_responder.sv
// Bench for lockstep_mem_responder: two instances (RESP_LAT 1 and 3) share one
// stimulus stream; expectations come from a per-transaction timeline model.
module tb_lockstep_mem_responder;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_SKEW = 4;
  localparam int SKW      = $clog2(MAX_SKEW + 1);

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        lReq, lWe, rReq, rWe;
  logic [3:0]  lBe, rBe;
  logic [31:0] lAddr, lWdata, rAddr, rWdata;
  logic [31:0] stimRdata;
  logic        stimErr;

  logic [1:0]     lGnt, lRvalid, lErr, rGnt, rRvalid, rErr, diverge, protoErr;
  logic [31:0]    lRdata [2];
  logic [31:0]    rRdata [2];
  logic [SKW-1:0] skew   [2];

  int checks = 0;
  int errors = 0;
  bit protoSticky = 1'b0;

  lockstep_mem_responder #(.AW(AW), .DW(DW), .MAX_SKEW(MAX_SKEW), .RESP_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .left_req_i(lReq), .left_we_i(lWe), .left_be_i(lBe), .left_addr_i(lAddr),
    .left_wdata_i(lWdata), .left_gnt_o(lGnt[0]), .left_rvalid_o(lRvalid[0]),
    .left_rdata_o(lRdata[0]), .left_err_o(lErr[0]),
    .right_req_i(rReq), .right_we_i(rWe), .right_be_i(rBe), .right_addr_i(rAddr),
    .right_wdata_i(rWdata), .right_gnt_o(rGnt[0]), .right_rvalid_o(rRvalid[0]),
    .right_rdata_o(rRdata[0]), .right_err_o(rErr[0]),
    .stim_rdata_i(stimRdata), .stim_err_i(stimErr),
    .skew_o(skew[0]), .diverge_o(diverge[0]), .protocol_err_o(protoErr[0])
  );

  lockstep_mem_responder #(.AW(AW), .DW(DW), .MAX_SKEW(MAX_SKEW), .RESP_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .left_req_i(lReq), .left_we_i(lWe), .left_be_i(lBe), .left_addr_i(lAddr),
    .left_wdata_i(lWdata), .left_gnt_o(lGnt[1]), .left_rvalid_o(lRvalid[1]),
    .left_rdata_o(lRdata[1]), .left_err_o(lErr[1]),
    .right_req_i(rReq), .right_we_i(rWe), .right_be_i(rBe), .right_addr_i(rAddr),
    .right_wdata_i(rWdata), .right_gnt_o(rGnt[1]), .right_rvalid_o(rRvalid[1]),
    .right_rdata_o(rRdata[1]), .right_err_o(rErr[1]),
    .stim_rdata_i(stimRdata), .stim_err_i(stimErr),
    .skew_o(skew[1]), .diverge_o(diverge[1]), .protocol_err_o(protoErr[1])
  );

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input int inst,
                             input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s (lat%0d instance) observed=0x%0h expected=0x%0h",
             tag, (inst == 0) ? 1 : 3, obs, exp);
    end
  endtask

  // Compare every output of one instance against expected values; expS < 0 skips skew.
  task automatic checkCycle(input int i, input bit expG, input bit expV,
                            input logic [31:0] expD, input bit expE, input int expS,
                            input bit expDv, input bit expPe);
    checkOutput("left_gnt",     i, 32'(lGnt[i]),     32'(expG));
    checkOutput("right_gnt",    i, 32'(rGnt[i]),     32'(expG));
    checkOutput("left_rvalid",  i, 32'(lRvalid[i]),  32'(expV));
    checkOutput("right_rvalid", i, 32'(rRvalid[i]),  32'(expV));
    checkOutput("left_rdata",   i, lRdata[i],        expD);
    checkOutput("right_rdata",  i, rRdata[i],        expD);
    checkOutput("left_err",     i, 32'(lErr[i]),     32'(expE));
    checkOutput("right_err",    i, 32'(rErr[i]),     32'(expE));
    checkOutput("diverge",      i, 32'(diverge[i]),  32'(expDv));
    checkOutput("protocol_err", i, 32'(protoErr[i]), 32'(expPe));
    if (expS >= 0) checkOutput("skew", i, 32'(skew[i]), 32'(expS));
  endtask

  task automatic applyReset();
    rst = 1'b1;
    lReq = 1'b0;
    rReq = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) checkCycle(i, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    protoSticky = 1'b0;
  endtask

  // One transaction: Left asserts req at cycle tl, Right at tr. Expected
  // behaviour follows from the arrival gap and whether the tuples agree:
  // gap <= MAX_SKEW and equal -> gnt one cycle after the later arrival,
  // rvalid RESP_LAT after that; otherwise divergence is flagged.
  task automatic applyStimulus(input int tl, input int tr, input txn_t a, input txn_t b,
                               input logic [31:0] stim, input bit serr,
                               input int resetAt, output bit granted);
    int mn, mx, d, g, divAt, last, lat, expS;
    bit cut, expG, expV, expE, expDv, active;
    logic [31:0] expD;
    mn      = (tl < tr) ? tl : tr;
    mx      = (tl < tr) ? tr : tl;
    d       = mx - mn;
    g       = mx + 1;
    granted = (d <= MAX_SKEW) && (a == b);
    if (d > MAX_SKEW)     divAt = mn + MAX_SKEW + 1;
    else if (a != b)      divAt = mx + 1;
    else                  divAt = -1;
    last = granted ? g + 3 : ((mx > divAt) ? mx : divAt) + 2;
    for (int k = 0; k <= last; k++) begin
      cut = (resetAt >= 0) && (k > resetAt);
      for (int i = 0; i < 2; i++) begin
        lat   = (i == 0) ? 1 : 3;
        expG  = !cut && granted && (k == g);
        expV  = !cut && granted && (k == g + lat);
        expD  = (expV && !a.we) ? stim : 32'h0;
        expE  = expV && serr;
        expDv = !cut && (divAt >= 0) && (k >= divAt);
        if (cut)                            expS = 0;
        else if (divAt >= 0 && k >= divAt)  expS = -1;
        else if (k > mn && k <= mx)         expS = k - mn;
        else if (granted && k == g)         expS = d;
        else                                expS = 0;
        checkCycle(i, expG, expV, expD, expE, expS, expDv, cut ? 1'b0 : protoSticky);
      end
      active    = (resetAt < 0) || (k < resetAt);
      rst       = (k == resetAt);
      lReq      = active && (k >= tl) && (!granted || k <= g);
      rReq      = active && (k >= tr) && (!granted || k <= g);
      lWe = a.we; lBe = a.be; lAddr = a.addr; lWdata = a.wdata;
      rWe = b.we; rBe = b.be; rAddr = b.addr; rWdata = b.wdata;
      stimRdata = (k == g) ? stim : $urandom;
      stimErr   = (k == g) ? serr : 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    lReq = 1'b0;
    rReq = 1'b0;
    if (resetAt >= 0) protoSticky = 1'b0;
  endtask

  initial begin
    txn_t a, b;
    bit ok;
    int tmin, d;
    rst = 1'b1;
    lReq = 1'b0; lWe = 1'b0; lBe = 4'h0; lAddr = 32'h0; lWdata = 32'h0;
    rReq = 1'b0; rWe = 1'b0; rBe = 4'h0; rAddr = 32'h0; rWdata = 32'h0;
    stimRdata = 32'h0;
    stimErr   = 1'b0;
    applyReset();

    $display("[TB] same-cycle matched read");
    a = '{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0};
    applyStimulus(0, 0, a, a, 32'hDEADBEEF, 1'b0, -1, ok);

    $display("[TB] skewed matched write");
    a = '{we: 1'b1, be: 4'hF, addr: 32'h40, wdata: 32'h1234_5678};
    applyStimulus(0, 3, a, a, 32'hCAFEF00D, 1'b0, -1, ok);

    $display("[TB] skew bound exceeded");
    a = '{we: 1'b0, be: 4'hF, addr: 32'h200, wdata: 32'h0};
    applyStimulus(0, 7, a, a, 32'h1111_2222, 1'b0, -1, ok);
    applyReset();

    $display("[TB] same-cycle address mismatch");
    a = '{we: 1'b0, be: 4'hF, addr: 32'h10, wdata: 32'h0};
    b = a;
    b.addr = 32'h14;
    applyStimulus(0, 0, a, b, 32'h3333_4444, 1'b0, -1, ok);
    applyReset();

    $display("[TB] waiting lane drops req");
    for (int k = 0; k <= 4; k++) begin
      for (int i = 0; i < 2; i++)
        checkCycle(i, 1'b0, 1'b0, 32'h0, 1'b0, (k == 1) ? 1 : ((k == 2) ? 2 : 0),
                   1'b0, k >= 3);
      lReq = (k < 2);
      rReq = 1'b0;
      @(posedge clk);
      #1;
    end
    lReq = 1'b0;
    protoSticky = 1'b1;
    a = '{we: 1'b0, be: 4'h3, addr: 32'h80, wdata: 32'h0};
    applyStimulus(1, 0, a, a, 32'h5555_6666, 1'b1, -1, ok);
    applyReset();

    $display("[TB] reset during response");
    a = '{we: 1'b0, be: 4'hF, addr: 32'h300, wdata: 32'h0};
    applyStimulus(0, 0, a, a, 32'h7777_8888, 1'b1, 2, ok);
    applyStimulus(0, 0, a, a, 32'h9999_AAAA, 1'b0, -1, ok);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      a.we    = 1'($urandom);
      a.be    = 4'($urandom);
      a.addr  = $urandom;
      a.wdata = $urandom;
      b = a;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0:       b.we    = ~b.we;
          1:       b.be    = b.be ^ (4'h1 << $urandom_range(0, 3));
          2:       b.addr  = b.addr ^ (32'h1 << $urandom_range(0, 31));
          default: b.wdata = b.wdata ^ (32'h1 << $urandom_range(0, 31));
        endcase
      end
      tmin = int'($urandom_range(0, 2));
      d    = int'($urandom_range(0, MAX_SKEW + 2));
      if ($urandom_range(0, 1) == 0)
        applyStimulus(tmin, tmin + d, a, b, $urandom, 1'($urandom), -1, ok);
      else
        applyStimulus(tmin + d, tmin, a, b, $urandom, 1'($urandom), -1, ok);
      if (!ok) applyReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lockstep_mem_responder.md
Name: lockstep_mem_responder

Overview:
- Shared memory responder for the self-composed product harness. It serves the Left and Right core copies on their ibex-style req/gnt/rvalid data ports.
- It returns one identical symbolic response to both copies. It absorbs timing skew between the copies (stuttering) up to a bound.
- It raises a sticky divergence flag when the copies issue different requests, or when their skew exceeds the bound.
- It is the responder end of the bus whose outputs the product harness compares for src_cand_equiv.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_SKEW, 4, max cycles one lane may wait for the other lane's matching request.
- RESP_LAT, 1, cycles from the grant cycle to rvalid (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- left_req_i  in  1  Left request.
- left_we_i  in  1  Left write enable.
- left_be_i  in  DW/8  Left byte enables.
- left_addr_i  in  AW  Left address.
- left_wdata_i  in  DW  Left write data.
- left_gnt_o  out  1  Left grant.
- left_rvalid_o  out  1  Left response valid.
- left_rdata_o  out  DW  Left read data.
- left_err_o  out  1  Left bus error.
- right_*: same seven signals for the Right lane.
- stim_rdata_i  in  DW  symbolic read data; sampled on the grant cycle.
- stim_err_i  in  1  symbolic error; sampled on the grant cycle.
- skew_o  out  $clog2(MAX_SKEW+1)  current wait count.
- diverge_o  out  1  sticky: requests mismatched or skew bound exceeded.
- protocol_err_o  out  1  sticky: req dropped before gnt.

Behaviour:
- Reset (synchronous, active-high, rst_i):
  - All outputs go to 0 and the FSM goes to IDLE.
  - A reset asserted mid-transaction drops the pending response; no rvalid is issued afterwards.
- Single outstanding transaction. A new grant is issued only after rvalid of the previous transaction.
- FSM states: IDLE, WAIT_L, WAIT_R, GRANT, RESP, DIVERGED.
- IDLE:
  - Both req=1: compare {we, be, addr, wdata}.
  - Equal: go to GRANT.
  - Unequal: set diverge_o and go to DIVERGED.
  - Only Right req: go to WAIT_L with skew=1.
  - Only Left req: go to WAIT_R with skew=1.
- WAIT_L / WAIT_R:
  - The waiting lane's req must stay high. If it drops, set protocol_err_o and go to IDLE with skew=0.
  - The lagging lane asserts req: compare attributes; equal goes to GRANT, unequal goes to DIVERGED.
  - Otherwise skew increments. When skew would exceed MAX_SKEW, set diverge_o and go to DIVERGED.
- GRANT:
  - Lasts one cycle.
  - left_gnt_o = right_gnt_o = 1.
  - Latch stim_rdata_i and stim_err_i.
  - Set skew to 0; go to RESP.
- RESP:
  - Count RESP_LAT-1 idle cycles.
  - Then assert left_rvalid_o = right_rvalid_o = 1 for one cycle, on the same cycle for both lanes.
  - rdata_o is the latched data for reads and 0 for writes; err_o is the latched error.
  - Then go to IDLE.
  - req high during RESP is held pending. It is evaluated in IDLE on the next cycle, so the minimum spacing is 1 cycle after rvalid.
- DIVERGED:
  - Absorbing until reset; no further gnt or rvalid.
  - diverge_o stays 1.
- Outputs are registered. gnt is never combinational from req; the earliest gnt is 1 cycle after both reqs are observed.
- The skew counter saturates at MAX_SKEW. Requests are compared once both lanes have asserted req; when both assert req in IDLE on the same cycle, the comparison uses that cycle's values.
- Width rules: attribute compare is a full-width equality; be participates even for reads.

Decomposition:
- Shared package lockstep_pkg:
  - state enum resp_state_e.
  - struct bus_req_t {we, be, addr, wdata}.
  - function req_equal().
- One sub-module, lockstep_skew_ctr: saturating counter with clear, increment and overflow outputs.

Test Plan:
- Both lanes request read addr 0x100 in the same cycle, stim_rdata_i=0xDEADBEEF, RESP_LAT=1:
  - gnt on both lanes 1 cycle later.
  - rvalid on both lanes the next cycle with rdata=0xDEADBEEF.
  - diverge_o=0.
- Left requests at cycle 0, Right at cycle 3, same write to 0x40 with be=0xF:
  - skew_o counts 1,2,3.
  - gnt on both lanes at cycle 4, rvalid at cycle 5 with rdata=0.
  - diverge_o=0.
- Left waits with no Right request for MAX_SKEW+1=5 cycles:
  - diverge_o=1 at the 5th cycle.
  - No gnt is ever issued afterwards, even when Right later requests.
- Both lanes request in the same cycle, addr 0x10 vs 0x14:
  - diverge_o=1 the next cycle; no gnt.
- Left requests, then drops req after 2 cycles with no gnt:
  - protocol_err_o=1; FSM returns to IDLE; skew_o=0.
- rst_i asserted in RESP with RESP_LAT=3:
  - No rvalid is issued; all outputs are 0 the cycle after reset.
  - A fresh matched request afterwards is granted normally.
